// File: rtl/lstm_weight_fetch.sv
// AXI4 read-master that fetches a contiguous word block in INCR bursts and streams it out.
// Optional macro LSTM_FETCH_RESP_CHECK_EN: flag rresp errors and rlast/beat-count disagreement in err.
module lstm_weight_fetch #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 32,
    parameter int MAX_BURST  = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              sys_clock,
    input  logic              reset_rtl,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [11:0]       num_words,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [7:0]        m_axi_arlen,
    output logic [2:0]        m_axi_arsize,
    output logic [1:0]        m_axi_arburst,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rlast,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    // Wide enough for base + 4*4095 so the range check never wraps.
    localparam int SUM_W = ((ADDR_W > 14) ? ADDR_W : 14) + 1;
    localparam logic [SUM_W-1:0] ADDR_SPAN = SUM_W'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ADDR  = 3'd2,
        S_DATA  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    state_t             state_r;
    state_t             next_s;
    logic [ADDR_W-1:0]  addr_r;
    logic [11:0]        remaining_r;
    logic [8:0]         burst_len_r;
    logic [8:0]         beat_cnt_r;
    logic [ADDR_W-1:0]  araddr_r;
    logic [7:0]         arlen_r;
    logic               arvalid_r;
    logic               rready_r;
    logic               err_r;
    logic               done_r;
    logic               busy_r;

    logic [DATA_W:0]    fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   fifo_cnt_r;
    logic [DATA_W-1:0]  out_data_r;
    logic               out_valid_r;
    logic               out_last_r;

    logic [8:0]         len_s;
    logic               credit_ok_s;
    logic [SUM_W-1:0]   end_addr_s;
    logic               range_bad_s;
    logic               beat_s;
    logic               final_beat_s;
    logic               push_last_s;
    logic               pop_s;
    logic               out_done_s;

`ifdef LSTM_FETCH_RESP_CHECK_EN
`else
    logic               resp_unused_s;
    assign resp_unused_s = ^{m_axi_rresp, m_axi_rlast};
`endif

    // Burst sizing, FIFO credit, range check and handshake decode.
    always_comb begin
        len_s = 9'd0;
        if (remaining_r < 12'(MAX_BURST)) begin
            len_s = remaining_r[8:0];
        end else begin
            len_s = 9'(MAX_BURST);
        end
        credit_ok_s  = (16'(FIFO_DEPTH) - 16'(fifo_cnt_r)) >= {7'd0, len_s};
        end_addr_s   = SUM_W'(addr_r) + SUM_W'({remaining_r, 2'b00});
        range_bad_s  = (addr_r[1:0] != 2'b00) || (end_addr_s > ADDR_SPAN);
        beat_s       = rready_r && m_axi_rvalid;
        final_beat_s = beat_s && (beat_cnt_r == 9'd1);
        push_last_s  = (beat_cnt_r == 9'd1) && (remaining_r == {3'b000, burst_len_r});
        pop_s        = (fifo_cnt_r != CNT_W'(0)) && (!out_valid_r || out_ready);
        out_done_s   = out_valid_r && out_ready && out_last_r;
    end

    // State register.
    always_ff @(posedge sys_clock) begin
        if (reset_rtl) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    next_s = S_CHECK;
                end else begin
                    next_s = S_IDLE;
                end
            end
            S_CHECK: begin
                if ((remaining_r == 12'd0) || range_bad_s) begin
                    next_s = S_IDLE;
                end else begin
                    next_s = S_ADDR;
                end
            end
            S_ADDR: begin
                if (arvalid_r && m_axi_arready) begin
                    next_s = S_DATA;
                end else begin
                    next_s = S_ADDR;
                end
            end
            S_DATA: begin
                if (final_beat_s) begin
                    if (remaining_r > {3'b000, burst_len_r}) begin
                        next_s = S_ADDR;
                    end else begin
                        next_s = S_DRAIN;
                    end
                end else begin
                    next_s = S_DATA;
                end
            end
            S_DRAIN: begin
                if (out_done_s) begin
                    next_s = S_IDLE;
                end else begin
                    next_s = S_DRAIN;
                end
            end
            default: next_s = S_IDLE;
        endcase
    end

    // Request bookkeeping, AR channel, R-channel ready and status flags.
    always_ff @(posedge sys_clock) begin
        if (reset_rtl) begin
            addr_r      <= '0;
            remaining_r <= 12'd0;
            burst_len_r <= 9'd0;
            beat_cnt_r  <= 9'd0;
            araddr_r    <= '0;
            arlen_r     <= 8'd0;
            arvalid_r   <= 1'b0;
            rready_r    <= 1'b0;
            err_r       <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            busy_r <= (next_s != S_IDLE);
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        addr_r      <= base_addr;
                        remaining_r <= num_words;
                        err_r       <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (remaining_r == 12'd0) begin
                        done_r <= 1'b1;
                    end else if (range_bad_s) begin
                        err_r  <= 1'b1;
                        done_r <= 1'b1;
                    end
                end
                S_ADDR: begin
                    // Issue only when the whole burst fits, so rready never stalls.
                    if (!arvalid_r) begin
                        if (credit_ok_s) begin
                            arvalid_r   <= 1'b1;
                            araddr_r    <= addr_r;
                            arlen_r     <= 8'(len_s - 9'd1);
                            burst_len_r <= len_s;
                            beat_cnt_r  <= len_s;
                        end
                    end else if (m_axi_arready) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (beat_s) begin
                        beat_cnt_r <= beat_cnt_r - 9'd1;
`ifdef LSTM_FETCH_RESP_CHECK_EN
                        if ((m_axi_rresp != 2'b00) || (m_axi_rlast != (beat_cnt_r == 9'd1))) begin
                            err_r <= 1'b1;
                        end
`endif
                        if (beat_cnt_r == 9'd1) begin
                            rready_r    <= 1'b0;
                            addr_r      <= addr_r + ADDR_W'({burst_len_r, 2'b00});
                            remaining_r <= remaining_r - {3'b000, burst_len_r};
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_done_s) begin
                        done_r <= 1'b1;
                    end
                end
                default: begin
                    arvalid_r <= 1'b0;
                    rready_r  <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage; the top bit tags the final word of the request.
    always_ff @(posedge sys_clock) begin
        if (beat_s) begin
            fifo_mem_r[wr_ptr_r] <= {push_last_s, m_axi_rdata};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge sys_clock) begin
        if (reset_rtl) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            fifo_cnt_r <= '0;
        end else begin
            if (beat_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({beat_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_W'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_W'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // Output register stage; holds steady while stalled.
    always_ff @(posedge sys_clock) begin
        if (reset_rtl) begin
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (pop_s) begin
            out_data_r  <= fifo_mem_r[rd_ptr_r][DATA_W-1:0];
            out_last_r  <= fifo_mem_r[rd_ptr_r][DATA_W];
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign err           = err_r;
    assign m_axi_araddr  = araddr_r;
    assign m_axi_arlen   = arlen_r;
    assign m_axi_arsize  = 3'b010;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = arvalid_r;
    assign m_axi_rready  = rready_r;
    assign out_data      = out_data_r;
    assign out_valid     = out_valid_r;
    assign out_last      = out_last_r;

endmodule

// File: tb/tb_lstm_weight_fetch.sv
// Directed bench for lstm_weight_fetch with a behavioural AXI read slave over a 4 KB word memory.
module tb_lstm_weight_fetch;

    logic        sys_clock = 1'b0;
    logic        reset_rtl;
    logic        start;
    logic [11:0] base_addr;
    logic [11:0] num_words;
    logic        busy, done, err;
    logic [11:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid, m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic [31:0] out_data;
    logic        out_valid, out_ready, out_last;

    int n_checks = 0;
    int n_errors = 0;

    lstm_weight_fetch dut (
        .sys_clock(sys_clock), .reset_rtl(reset_rtl), .start(start),
        .base_addr(base_addr), .num_words(num_words),
        .busy(busy), .done(done), .err(err),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    always #5 sys_clock = ~sys_clock;

    // Slave model: memory, optional AR stall, optional error response on one beat.
    logic [31:0] mem [1024];
    logic        r_active = 1'b0;
    logic [11:0] r_addr = 12'd0;
    logic [8:0]  r_left = 9'd0;
    logic [8:0]  r_beat = 9'd0;
    logic [8:0]  err_beat = 9'd511;
    int          ar_delay = 0;
    int          ar_wait = 0;
    logic [11:0] ar_addr_q[$];
    logic [7:0]  ar_len_q[$];

    assign m_axi_arready = (ar_wait >= ar_delay);
    assign m_axi_rvalid  = r_active;
    assign m_axi_rdata   = mem[r_addr[11:2]];
    assign m_axi_rlast   = (r_left == 9'd1);
    assign m_axi_rresp   = (r_beat == err_beat) ? 2'b10 : 2'b00;

    always @(posedge sys_clock) begin
        if (reset_rtl) begin
            r_active <= 1'b0;
            r_left   <= 9'd0;
            r_beat   <= 9'd0;
            ar_wait  <= 0;
        end else begin
            if (m_axi_rvalid && m_axi_rready) begin
                r_addr <= r_addr + 12'd4;
                r_left <= r_left - 9'd1;
                r_beat <= r_beat + 9'd1;
                if (r_left == 9'd1) r_active <= 1'b0;
            end
            if (m_axi_arvalid && m_axi_arready) begin
                ar_addr_q.push_back(m_axi_araddr);
                ar_len_q.push_back(m_axi_arlen);
                r_active <= 1'b1;
                r_addr   <= m_axi_araddr;
                r_left   <= 9'(m_axi_arlen) + 9'd1;
                r_beat   <= 9'd0;
                ar_wait  <= 0;
            end else if (m_axi_arvalid) begin
                ar_wait <= ar_wait + 1;
            end
        end
    end

    // Mid-cycle monitor: output handshakes, done pulses, arvalid activity.
    logic [31:0] cap_data[$];
    logic        cap_last[$];
    int          done_cnt = 0;
    int          arv_cycles = 0;

    always @(negedge sys_clock) begin
        if (!reset_rtl) begin
            if (done) done_cnt++;
            if (m_axi_arvalid) arv_cycles++;
            if (out_valid && out_ready) begin
                cap_data.push_back(out_data);
                cap_last.push_back(out_last);
            end
        end
    end

    function automatic logic [31:0] exp_word(input logic [11:0] a);
        if (a == 12'h100) return 32'hDEADBEEF;
        return {16'hC0DE, 6'd0, a[11:2]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic start_req(input logic [11:0] b, input logic [11:0] n);
        @(posedge sys_clock); #2;
        cap_data.delete(); cap_last.delete();
        ar_addr_q.delete(); ar_len_q.delete();
        done_cnt = 0; arv_cycles = 0;
        base_addr = b; num_words = n; start = 1'b1;
        @(posedge sys_clock); #2;
        start = 1'b0;
    endtask

    task automatic wait_done(input int mode, input int limit);
        int cyc = 0;
        bit seen = 1'b0;
        while (!seen && cyc < limit) begin
            if (done_cnt != 0) begin
                seen = 1'b1;
            end else begin
                out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) != 2);
                @(posedge sys_clock); #2;
                cyc++;
            end
        end
        chk("done_seen", {63'd0, seen}, 64'd1);
        out_ready = 1'b1;
        repeat (3) begin @(posedge sys_clock); #2; end
    endtask

    task automatic check_result(input logic [11:0] b, input logic [11:0] n, input logic exp_err,
                                input int exp_words, input int exp_nar);
        logic [11:0] a;
        int rem, len, k;
        chk("err", {63'd0, err}, {63'd0, exp_err});
        chk("done_pulses", 64'(done_cnt), 64'd1);
        chk("busy_after", {63'd0, busy}, 64'd0);
        chk("word_count", 64'(cap_data.size()), 64'(exp_words));
        a = b;
        for (int i = 0; i < exp_words && i < cap_data.size(); i++) begin
            chk("word", {31'd0, cap_last[i], cap_data[i]}, {31'd0, (i == exp_words - 1), exp_word(a)});
            a = a + 12'd4;
        end
        chk("ar_count", 64'(ar_addr_q.size()), 64'(exp_nar));
        if (exp_nar == 0) chk("no_arvalid", 64'(arv_cycles), 64'd0);
        a = b; rem = int'(n); k = 0;
        while (rem > 0 && k < ar_addr_q.size() && exp_nar > 0) begin
            len = (rem < 16) ? rem : 16;
            chk("ar_addr", 64'(ar_addr_q[k]), 64'(a));
            chk("ar_len", 64'(ar_len_q[k]), 64'(len - 1));
            a = a + 12'(4 * len);
            rem = rem - len;
            k++;
        end
    endtask

    typedef struct {
        logic [11:0] base;
        logic [11:0] num;
        int          mode;
        int          ar_dly;
        logic        exp_err;
        int          exp_words;
        int          exp_nar;
    } vec_t;

    vec_t vecs[10];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_resp_err;
        int   wcnt;
        vecs[0] = '{12'h100, 12'd1,    0, 0, 1'b0, 1,    1};
        vecs[1] = '{12'h000, 12'd40,   0, 0, 1'b0, 40,   3};
        vecs[2] = '{12'hFF0, 12'd5,    0, 0, 1'b1, 0,    0};
        vecs[3] = '{12'hFF0, 12'd4,    1, 0, 1'b0, 4,    1};
        vecs[4] = '{12'h200, 12'd0,    0, 0, 1'b0, 0,    0};
        vecs[5] = '{12'h102, 12'd1,    0, 0, 1'b1, 0,    0};
        vecs[6] = '{12'h004, 12'd17,   1, 3, 1'b0, 17,   2};
        vecs[7] = '{12'h000, 12'd1024, 0, 0, 1'b0, 1024, 64};
        vecs[8] = '{12'h004, 12'd1024, 0, 0, 1'b1, 0,    0};
        vecs[9] = '{12'hFFC, 12'd1,    1, 2, 1'b0, 1,    1};

        for (int i = 0; i < 1024; i++) mem[i] = {16'hC0DE, 6'd0, 10'(i)};
        mem[64] = 32'hDEADBEEF;

        reset_rtl = 1'b1; start = 1'b0; base_addr = 12'd0; num_words = 12'd0; out_ready = 1'b1;
        repeat (3) @(posedge sys_clock);
        #2;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_arvalid", {63'd0, m_axi_arvalid}, 64'd0);
        chk("rst_rready", {63'd0, m_axi_rready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_last", {63'd0, out_last}, 64'd0);
        chk("rst_araddr", 64'(m_axi_araddr), 64'd0);
        chk("rst_arlen", 64'(m_axi_arlen), 64'd0);
        chk("rst_arsize", 64'(m_axi_arsize), 64'd2);
        chk("rst_arburst", 64'(m_axi_arburst), 64'd1);
        reset_rtl = 1'b0;

        for (int v = 0; v < 10; v++) begin
            ar_delay = vecs[v].ar_dly;
            start_req(vecs[v].base, vecs[v].num);
            wait_done(vecs[v].mode, 4000);
            check_result(vecs[v].base, vecs[v].num, vecs[v].exp_err, vecs[v].exp_words, vecs[v].exp_nar);
        end
        ar_delay = 0;

        // Back-pressure: second burst must wait for the FIFO to drain.
        out_ready = 1'b0;
        start_req(12'h000, 12'd32);
        repeat (60) begin @(posedge sys_clock); #2; end
        chk("bp_ar_count", 64'(ar_addr_q.size()), 64'd1);
        chk("bp_arvalid", {63'd0, m_axi_arvalid}, 64'd0);
        chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_out_data", 64'(out_data), 64'(exp_word(12'h000)));
        chk("bp_no_pop", 64'(cap_data.size()), 64'd0);
        wait_done(0, 2000);
        check_result(12'h000, 12'd32, 1'b0, 32, 2);

        // Reset in the middle of a 16-beat burst, then a fresh request.
        out_ready = 1'b1;
        start_req(12'h000, 12'd16);
        wcnt = 0;
        while (r_beat < 9'd5 && wcnt < 100) begin @(posedge sys_clock); #2; wcnt++; end
        chk("mid_burst_reached", {63'd0, (r_beat >= 9'd5)}, 64'd1);
        reset_rtl = 1'b1;
        @(posedge sys_clock); #2;
        chk("mr_busy", {63'd0, busy}, 64'd0);
        chk("mr_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mr_arvalid", {63'd0, m_axi_arvalid}, 64'd0);
        chk("mr_rready", {63'd0, m_axi_rready}, 64'd0);
        reset_rtl = 1'b0;
        start_req(12'h300, 12'd3);
        wait_done(0, 1000);
        check_result(12'h300, 12'd3, 1'b0, 3, 1);

        // Error response on beat 3 of 4: data still forwarded.
`ifdef LSTM_FETCH_RESP_CHECK_EN
        exp_resp_err = 1'b1;
`else
        exp_resp_err = 1'b0;
`endif
        err_beat = 9'd2;
        start_req(12'h040, 12'd4);
        wait_done(0, 1000);
        check_result(12'h040, 12'd4, exp_resp_err, 4, 1);
        err_beat = 9'd511;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
